bank_account_server: RTL

Host-side responder for ATM transaction requests. Holds a small register-file table of provisioned accounts and accepts one request at a time over a valid/ready channel. For each request it verifies card and PIN, enforces PIN-retry lockout, and executes deposit, withdraw or balance inquiry. It returns a status code and the resulting balance. It sits behind the ATM front-end FSM and is the single owner of account balances.

---
 rtl/bank_account_server.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/bank_account_server.sv
// Account-table responder for ATM requests: card/PIN check, retry lockout, deposit/withdraw/balance.
// Optional response-hold timeout is enabled by defining BANK_RSP_TIMEOUT_EN.
module bank_account_server #(
  parameter int NUM_ACCTS   = 4,
  parameter int BAL_W       = 5,
  parameter int MAX_TRIES   = 3,
  parameter int RSP_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [7:0]                   req_cardno,
  input  logic [3:0]                   req_pin,
  input  logic [2:0]                   req_op,
  input  logic [BAL_W-1:0]             req_amount,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [2:0]                   rsp_status,
  output logic [BAL_W-1:0]             rsp_balance,
  input  logic                         prov_we,
  input  logic [$clog2(NUM_ACCTS)-1:0] prov_idx,
  input  logic [7:0]                   prov_cardno,
  input  logic [3:0]                   prov_pin,
  input  logic [BAL_W-1:0]             prov_balance
);

  localparam int IDX_W = $clog2(NUM_ACCTS);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_EXEC, S_RESP} state_t;
  typedef enum logic [2:0] {
    ST_OK       = 3'b000,
    ST_NO_CARD  = 3'b001,
    ST_BAD_PIN  = 3'b010,
    ST_LOCKED   = 3'b011,
    ST_INSUFF   = 3'b100,
    ST_OVERFLOW = 3'b101,
    ST_BAD_OP   = 3'b110
  } status_t;

  state_t state, state_nxt;

  logic [7:0]       tbl_card [NUM_ACCTS];
  logic [3:0]       tbl_pin  [NUM_ACCTS];
  logic [BAL_W-1:0] tbl_bal  [NUM_ACCTS];
  logic [1:0]       tbl_fail [NUM_ACCTS];
  logic             tbl_lock [NUM_ACCTS];

  logic [7:0]       cap_card;
  logic [3:0]       cap_pin;
  logic [2:0]       cap_op;
  logic [BAL_W-1:0] cap_amt;
  logic             hit_q;
  logic [IDX_W-1:0] idx_q;
  status_t          rsp_st_q;
  logic [BAL_W-1:0] rsp_bal_q;

  logic             lk_hit;
  logic [IDX_W-1:0] lk_idx;

  status_t          ex_status;
  logic [BAL_W-1:0] ex_bal_rsp;
  logic [BAL_W-1:0] upd_bal;
  logic [1:0]       upd_fail;
  logic             upd_lock;
  logic [BAL_W:0]   sum;
  logic             op_dep, op_wd, op_bq;

`ifdef BANK_RSP_TIMEOUT_EN
  localparam int TO_W = $clog2(RSP_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_expired;
  assign to_expired = (to_cnt == TO_W'(RSP_TIMEOUT - 1));
`endif

  assign rsp_status  = rsp_st_q;
  assign rsp_balance = rsp_bal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = S_LOOKUP;
      end
      S_LOOKUP: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
`ifdef BANK_RSP_TIMEOUT_EN
        else if (to_expired) state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lowest matching index wins; card 0 never matches.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int unsigned i = 0; i < NUM_ACCTS; i++) begin
      if (!lk_hit && cap_card != 8'd0 && tbl_card[i] == cap_card) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    op_dep     = (cap_op == 3'b001);
    op_wd      = (cap_op == 3'b010);
    op_bq      = (cap_op == 3'b011);
    sum        = {1'b0, tbl_bal[idx_q]} + {1'b0, cap_amt};
    ex_status  = ST_OK;
    ex_bal_rsp = '0;
    upd_bal    = tbl_bal[idx_q];
    upd_fail   = tbl_fail[idx_q];
    upd_lock   = tbl_lock[idx_q];
    if (!hit_q) begin
      ex_status = ST_NO_CARD;
    end else if (tbl_lock[idx_q]) begin
      ex_status = ST_LOCKED;
    end else if (cap_pin != tbl_pin[idx_q]) begin
      ex_status = ST_BAD_PIN;
      upd_fail  = tbl_fail[idx_q] + 2'd1;
      if (int'(upd_fail) >= MAX_TRIES) upd_lock = 1'b1;
    end else begin
      upd_fail = '0;
      if (!(op_dep || op_wd || op_bq) || ((op_dep || op_wd) && cap_amt == '0)) begin
        ex_status = ST_BAD_OP;
      end else if (op_dep && sum[BAL_W]) begin
        ex_status = ST_OVERFLOW;
      end else if (op_wd && cap_amt > tbl_bal[idx_q]) begin
        ex_status = ST_INSUFF;
      end else begin
        if (op_dep)     upd_bal = sum[BAL_W-1:0];
        else if (op_wd) upd_bal = tbl_bal[idx_q] - cap_amt;
        ex_bal_rsp = upd_bal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ACCTS; i++) begin
        tbl_card[i] <= '0;
        tbl_pin[i]  <= '0;
        tbl_bal[i]  <= '0;
        tbl_fail[i] <= '0;
        tbl_lock[i] <= 1'b0;
      end
      cap_card  <= '0;
      cap_pin   <= '0;
      cap_op    <= '0;
      cap_amt   <= '0;
      hit_q     <= 1'b0;
      idx_q     <= '0;
      rsp_st_q  <= ST_OK;
      rsp_bal_q <= '0;
`ifdef BANK_RSP_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (prov_we && int'(prov_idx) < NUM_ACCTS) begin
            tbl_card[prov_idx] <= prov_cardno;
            tbl_pin[prov_idx]  <= prov_pin;
            tbl_bal[prov_idx]  <= prov_balance;
            tbl_fail[prov_idx] <= '0;
            tbl_lock[prov_idx] <= 1'b0;
          end
          if (req_valid) begin
            cap_card <= req_cardno;
            cap_pin  <= req_pin;
            cap_op   <= req_op;
            cap_amt  <= req_amount;
          end
        end
        S_LOOKUP: begin
          hit_q <= lk_hit;
          idx_q <= lk_idx;
        end
        S_EXEC: begin
          if (hit_q) begin
            tbl_bal[idx_q]  <= upd_bal;
            tbl_fail[idx_q] <= upd_fail;
            tbl_lock[idx_q] <= upd_lock;
          end
          rsp_st_q  <= ex_status;
          rsp_bal_q <= ex_bal_rsp;
`ifdef BANK_RSP_TIMEOUT_EN
          to_cnt    <= '0;
`endif
        end
        S_RESP: begin
`ifdef BANK_RSP_TIMEOUT_EN
          if (!to_expired) to_cnt <= to_cnt + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
